// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session timer and counter consumers.
// Holds the timer state enum and the default width/load/warning constants.
package atm_pkg;

    localparam int unsigned ATM_WIDTH        = 8;
    localparam int unsigned ATM_DEFAULT_LOAD = 60;
    localparam int unsigned ATM_WARN_THRESH  = 10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } timer_state_e;

endpackage

// File: rtl/atm_session_timer.sv
// Down-counting session timer: load, start/pause, reload on activity,
// warning window, one-cycle expiry pulse and sticky timed_out level.
// Ports: clk, rst_n (async low), tick/load/load_val/start/pause/activity in;
//        Q (remaining), running, warn, expired, timed_out out (all registered).
module atm_session_timer
    import atm_pkg::*;
#(
    parameter int unsigned WIDTH        = ATM_WIDTH,
    parameter int unsigned DEFAULT_LOAD = ATM_DEFAULT_LOAD,
    parameter int unsigned WARN_THRESH  = ATM_WARN_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             activity,
    output logic [WIDTH-1:0] Q,
    output logic             running,
    output logic             warn,
    output logic             expired,
    output logic             timed_out
);

    localparam logic [WIDTH-1:0] DLOAD = WIDTH'(DEFAULT_LOAD);
    localparam logic [WIDTH-1:0] WTHR  = WIDTH'(WARN_THRESH);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    timer_state_e     state;
    timer_state_e     state_n;
    logic [WIDTH-1:0] rel;
    logic [WIDTH-1:0] rel_n;
    logic [WIDTH-1:0] q_n;
    logic             exp_n;
    logic             to_n;
    logic             run_n;
    logic             warn_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            Q         <= '0;
            rel       <= '0;
            running   <= 1'b0;
            warn      <= 1'b0;
            expired   <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_n;
            Q         <= q_n;
            rel       <= rel_n;
            running   <= run_n;
            warn      <= warn_n;
            expired   <= exp_n;
            timed_out <= to_n;
        end
    end

    // Highest asserted event owns the cycle, even if it is a no-op
    // in the current state; lower events are dropped.
    always_comb begin
        state_n = state;
        q_n     = Q;
        rel_n   = rel;
        exp_n   = 1'b0;
        to_n    = timed_out;
        priority case (1'b1)
            load: begin
                q_n     = (load_val == '0) ? DLOAD : load_val;
                rel_n   = q_n;
                state_n = S_IDLE;
                to_n    = 1'b0;
            end
            activity: begin
                if (state == S_RUN || state == S_PAUSED)
                    q_n = rel;
            end
            pause: begin
                if (state == S_RUN)
                    state_n = S_PAUSED;
            end
            start: begin
                if ((state == S_IDLE || state == S_PAUSED) && Q != '0)
                    state_n = S_RUN;
            end
            tick: begin
                if (state == S_RUN) begin
                    q_n = Q - ONE;
                    if (Q == ONE) begin
                        state_n = S_EXPIRED;
                        exp_n   = 1'b1;
                        to_n    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Flags are derived from the next state so they line up with Q.
    always_comb begin
        run_n  = (state_n == S_RUN);
        warn_n = run_n && (q_n != '0) && (q_n <= WTHR);
    end

endmodule

// File: tb/tb_atm_session_timer.sv
// Self-checking bench for atm_session_timer: directed steps plus
// randomized traffic compared against a behavioural model.
module tb_atm_session_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       activity = 1'b0;
    logic [7:0] Q;
    logic       running;
    logic       warn;
    logic       expired;
    logic       timed_out;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 counting, 2 paused, 3 expired
    int m_q = 0;
    int m_rel = 0;
    int m_mode = 0;
    bit m_exp = 0;
    bit m_to = 0;

    atm_session_timer dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
        .load_val(load_val), .start(start), .pause(pause),
        .activity(activity), .Q(Q), .running(running), .warn(warn),
        .expired(expired), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        bit run_e;
        run_e = (m_mode == 1);
        chk({tag, ".Q"}, int'(Q), m_q);
        chk({tag, ".running"}, int'(running), int'(run_e));
        chk({tag, ".warn"}, int'(warn),
            int'(run_e && m_q >= 1 && m_q <= 10));
        chk({tag, ".expired"}, int'(expired), int'(m_exp));
        chk({tag, ".timed_out"}, int'(timed_out), int'(m_to));
    endtask

    function automatic void model_reset();
        m_q = 0; m_rel = 0; m_mode = 0; m_exp = 0; m_to = 0;
    endfunction

    function automatic void model_step(bit ld, int lv, bit st,
                                       bit pa, bit ac, bit tk);
        m_exp = 0;
        if (ld) begin
            m_q = (lv == 0) ? 60 : lv;
            m_rel = m_q;
            m_mode = 0;
            m_to = 0;
        end else if (ac) begin
            if (m_mode == 1 || m_mode == 2) m_q = m_rel;
        end else if (pa) begin
            if (m_mode == 1) m_mode = 2;
        end else if (st) begin
            if ((m_mode == 0 || m_mode == 2) && m_q != 0) m_mode = 1;
        end else if (tk) begin
            if (m_mode == 1) begin
                m_q = m_q - 1;
                if (m_q == 0) begin
                    m_mode = 3; m_exp = 1; m_to = 1;
                end
            end
        end
    endfunction

    // Apply one cycle of inputs, step model, check #1 after the edge.
    task automatic cyc(input string tag, input bit ld, input int lv,
                       input bit st, input bit pa, input bit ac,
                       input bit tk);
        load = ld; load_val = 8'(lv); start = st;
        pause = pa; activity = ac; tick = tk;
        @(posedge clk);
        model_step(ld, lv, st, pa, ac, tk);
        #1;
        load = 0; start = 0; pause = 0; activity = 0; tick = 0;
        chk_all(tag);
    endtask

    initial begin
        // Reset state
        #2;
        chk_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("post_reset");

        // Load 5, count to expiry
        cyc("ld5", 1, 5, 0, 0, 0, 0);
        chk("ld5_q", int'(Q), 5);
        cyc("st5", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("tk5", 0, 0, 0, 0, 0, 1);
        chk("exp_pulse", int'(expired), 1);
        chk("exp_q0", int'(Q), 0);
        cyc("after_exp", 0, 0, 0, 0, 0, 0);
        chk("exp_gone", int'(expired), 0);
        chk("to_sticky", int'(timed_out), 1);

        // Default load and warning window
        cyc("ld0", 1, 0, 0, 0, 0, 0);
        chk("default60", int'(Q), 60);
        cyc("st60", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 50; i++) cyc("tk60", 0, 0, 0, 0, 0, 1);
        chk("q10", int'(Q), 10);
        chk("warn_at10", int'(warn), 1);
        for (int i = 0; i < 10; i++) cyc("tkw", 0, 0, 0, 0, 0, 1);
        chk("warn_at0", int'(warn), 0);

        // Activity reload and pause/resume
        cyc("ld20", 1, 20, 0, 0, 0, 0);
        cyc("st20", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc("tk20", 0, 0, 0, 0, 0, 1);
        chk("q13", int'(Q), 13);
        cyc("act", 0, 0, 0, 0, 1, 0);
        chk("act_q20", int'(Q), 20);
        cyc("pause", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("tkp", 0, 0, 0, 0, 0, 1);
        chk("pause_hold", int'(Q), 20);
        cyc("resume", 0, 0, 1, 0, 0, 0);
        cyc("tkr", 0, 0, 0, 0, 0, 1);
        chk("resume_q19", int'(Q), 19);

        // Load beats activity and tick
        cyc("ld4", 1, 4, 0, 0, 0, 0);
        cyc("st4", 0, 0, 1, 0, 0, 0);
        cyc("prio", 1, 9, 0, 0, 1, 1);
        chk("prio_q9", int'(Q), 9);
        chk("prio_idle", int'(running), 0);

        // Expired is sticky
        cyc("ld1", 1, 1, 0, 0, 0, 0);
        cyc("st1", 0, 0, 1, 0, 0, 0);
        cyc("tk1", 0, 0, 0, 0, 0, 1);
        cyc("ex_st", 0, 0, 1, 0, 0, 0);
        cyc("ex_ac", 0, 0, 0, 0, 1, 0);
        cyc("ex_tk", 0, 0, 0, 0, 0, 1);
        chk("ex_to", int'(timed_out), 1);
        cyc("ld3", 1, 3, 0, 0, 0, 0);
        chk("ld3_to", int'(timed_out), 0);
        chk("ld3_q", int'(Q), 3);

        // Async reset mid-run
        cyc("ld2", 1, 2, 0, 0, 0, 0);
        cyc("st2", 0, 0, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("st_q0", 0, 0, 1, 0, 0, 0);
        chk("st_q0_idle", int'(running), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit ld, st, pa, ac, tk;
            int lv;
            ld = ($urandom_range(0, 39) == 0);
            lv = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
            if ($urandom_range(0, 1) == 0) lv = $urandom_range(0, 14);
            st = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 29) == 0);
            ac = ($urandom_range(0, 59) == 0);
            tk = ($urandom_range(0, 1) == 0);
            cyc("rand", ld, lv, st, pa, ac, tk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atm_session_timer.md
Name: atm_session_timer

Overview:
- 8-bit down-counting session timer for the ATM controller; the down-counting counterpart of the free-running up counter.
- Loaded with a session length in seconds, decremented on each one-cycle `tick` enable from the slow-clock divider.
- Reloaded on user keypad activity.
- Flags a warning window near the end, then signals expiry so the top-level FSM can eject the card and return to idle.

Parameters:
- WIDTH, 8, counter/data width in bits.
- DEFAULT_LOAD, 8'd60, value loaded when `load` is asserted with `load_val` == 0.
- WARN_THRESH, 8'd10, `warn` asserts while remaining count <= this value.

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  single-cycle enable, one per second; decrement strobe.
- load  input  1  load `load_val` (or DEFAULT_LOAD if 0) into count and reload register; enters IDLE.
- load_val  input  WIDTH  session length to load.
- start  input  1  begin/resume counting.
- pause  input  1  freeze counting.
- activity  input  1  user keypress; restarts count from reload register.
- Q  output  WIDTH  remaining count.
- running  output  1  high in RUN.
- warn  output  1  high in RUN when 0 < Q <= WARN_THRESH.
- expired  output  1  one-cycle pulse on reaching zero.
- timed_out  output  1  level, high in EXPIRED until next `load`.

Behaviour:
- Reset, asynchronous on `rst_n` low, any state:
  - Q = 0, reload register = 0, state = IDLE.
  - `running` = 0, `warn` = 0, `expired` = 0, `timed_out` = 0.
  - Reset mid-count aborts immediately; no expiry pulse is generated.
- All outputs are registered. One-cycle latency: an input sampled at edge n is visible after edge n.
- States: IDLE, RUN, PAUSED, EXPIRED. Encoding is defined in the package.
- Per-cycle priority: `load` > `activity` > `pause` > `start` > `tick`. Only the highest-priority event acts; lower events that cycle are dropped.
- `load`, any state:
  - Q <= (`load_val` == 0 ? DEFAULT_LOAD : `load_val`).
  - Reload register <= same value.
  - state <= IDLE; `timed_out` <= 0.
- `activity`:
  - RUN: Q <= reload register; stay in RUN.
  - PAUSED: Q <= reload register; stay in PAUSED.
  - IDLE, EXPIRED: ignored.
- `pause`: RUN -> PAUSED. Ignored elsewhere.
- `start`:
  - IDLE or PAUSED, with Q != 0: -> RUN.
  - Q == 0: ignored; stay in the current state.
  - EXPIRED: ignored.
- `tick`, in RUN only:
  - Q > 1: Q <= Q - 1.
  - Q == 1: Q <= 0, state <= EXPIRED, `expired` <= 1 for exactly one cycle, `timed_out` <= 1.
  - Ticks outside RUN are ignored.
- Q never wraps; 0 - 1 is impossible because RUN is never entered with Q == 0.
- `warn` is combinational-free: registered from next-state RUN and next-Q in 1..WARN_THRESH. If WARN_THRESH >= load value, `warn` is high from the first RUN cycle.
- `running` = (state == RUN), registered.
- EXPIRED is sticky; only `load` or reset exits it.
- Maximum load 8'd255; counts down fully to 0 in 255 ticks.

Decomposition:
- Shared package `atm_pkg`: timer state enum (IDLE/RUN/PAUSED/EXPIRED), DEFAULT_LOAD and WARN_THRESH defaults, WIDTH constant shared with `eight_bit_counter` consumers.
- No sub-module required. `tick` is produced upstream by the existing slow-clock divider as a one-cycle enable; this block does not detect edges.

Test Plan:
- Reset then `load` `load_val`=5, `start`, 5 ticks -> Q steps 5,4,3,2,1,0. `expired` high exactly one cycle after the 5th tick; `timed_out` stays high; `running` drops.
- `load` `load_val`=0 -> Q=60. `start`, ticks until Q=10 -> `warn` rises on the cycle Q becomes 10 and stays high through Q=1; low at Q=0.
- `load` 20, `start`, 7 ticks (Q=13), `activity` -> Q=20 next cycle, still RUN. `pause`, 3 ticks -> Q holds at 20; `start` resumes decrementing.
- Same cycle `load`(val 9) + `activity` + `tick` in RUN at Q=4 -> Q=9, state IDLE, no decrement.
- In EXPIRED: `start`, `activity`, `tick` -> no change, `timed_out`=1. Then `load` 3 -> `timed_out`=0, Q=3, IDLE.
- `rst_n` low asynchronously mid-RUN at Q=2 -> Q=0, all flags 0 before next clk edge. After release, `start` with Q=0 -> stays IDLE.
